multi_pulse_sync: RTL and testbench

- N-channel asynchronous event capture block. Each channel takes an asynchronous level input, synchronises it into the single `clk` domain and glitch-filters it.
- Each channel detects edges according to a per-channel mode. Per detected edge it emits a one-cycle pulse, sets a sticky flag and increments a saturating event counter.
- Successor to the single-channel pulse synchroniser. Sits between slow or external event sources and local control logic / status registers.

---
 rtl/multi_pulse_sync.sv | 129 ++++++++++++
 tb/tb_multi_pulse_sync.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multi_pulse_sync.sv
// N-channel asynchronous event capture: per-channel synchroniser, glitch filter,
// mode-selected edge detect, one-cycle pulse, sticky flag and saturating counter.
module multi_pulse_sync #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 3,
  parameter int CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         async_in,
  input  logic [2*N-1:0]       mode,
  input  logic [N-1:0]         clr,
  output logic [N-1:0]         pulse_out,
  output logic [N-1:0]         flag,
  output logic [N*CNT_W-1:0]   evt_cnt
);

  localparam int FCW = $clog2(FILT_CYC) + 1;
  localparam logic [FCW-1:0]   FILT_LAST = FCW'(FILT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [N-1:0]     sync_d [SYNC_STAGES];
  logic [N-1:0]     s;
  logic [N-1:0]     filt_q, filt_d;
  logic [FCW-1:0]   fcnt_q [N];
  logic [FCW-1:0]   fcnt_d [N];
  logic [N-1:0]     evt;
  logic [N-1:0]     pulse_q, pulse_d;
  logic [N-1:0]     flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  always_comb begin
    sync_d[0] = async_in;
    for (int j = 1; j < SYNC_STAGES; j++) begin
      sync_d[j] = sync_q[j-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Filter keeps tracking even in MODE_OFF so re-enabling never sees a stale edge.
  always_comb begin
    filt_d = filt_q;
    evt    = '0;
    for (int i = 0; i < N; i++) begin
      fcnt_d[i] = fcnt_q[i];
      if (s[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FILT_LAST) begin
        filt_d[i] = s[i];
        fcnt_d[i] = '0;
        case (mode_e'(mode[2*i +: 2]))
          MODE_RISE: evt[i] = s[i];
          MODE_FALL: evt[i] = ~s[i];
          MODE_BOTH: evt[i] = 1'b1;
          default:   evt[i] = 1'b0;
        endcase
      end else begin
        fcnt_d[i] = fcnt_q[i] + FCW'(1);
      end
    end
  end

  // An event in the same cycle as a clear wins, leaving a count of one.
  always_comb begin
    pulse_d = evt;
    flag_d  = flag_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (evt[i]) begin
        flag_d[i] = 1'b1;
        if (clr[i]) begin
          cnt_d[i] = CNT_W'(1);
        end else if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (clr[i]) begin
        flag_d[i] = 1'b0;
        cnt_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= '0;
      end
      filt_q  <= '0;
      pulse_q <= '0;
      flag_q  <= '0;
      for (int i = 0; i < N; i++) begin
        fcnt_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= sync_d[j];
      end
      filt_q  <= filt_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      for (int i = 0; i < N; i++) begin
        fcnt_q[i] <= fcnt_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  always_comb begin
    pulse_out = pulse_q;
    flag      = flag_q;
    evt_cnt   = '0;
    for (int i = 0; i < N; i++) begin
      evt_cnt[CNT_W*i +: CNT_W] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_multi_pulse_sync.sv
// Self-checking bench for multi_pulse_sync: vector table plus corner sequences,
// with a scoreboard queue of expected pulse cycles checked every cycle.
module tb_multi_pulse_sync;

  localparam int N           = 4;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_CYC    = 3;
  localparam int CNT_W       = 4;
  localparam int LAT         = SYNC_STAGES + FILT_CYC;
  localparam int NVEC        = 7;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [N-1:0]         async_in = '0;
  logic [2*N-1:0]       mode = '1;
  logic [N-1:0]         clr = '0;
  logic [N-1:0]         pulse_out;
  logic [N-1:0]         flag;
  logic [N*CNT_W-1:0]   evt_cnt;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int due;
    int ch;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  typedef struct {
    logic [N-1:0]       in_mask;
    logic [2*N-1:0]     mode;
    int                 hi;
    int                 lo;
    logic [N-1:0]       exp_rise;
    logic [N-1:0]       exp_fall;
    logic [N-1:0]       exp_flag;
    logic [N*CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs [NVEC];

  multi_pulse_sync #(
    .N(N), .SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .async_in(async_in), .mode(mode), .clr(clr),
    .pulse_out(pulse_out), .flag(flag), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a level on the masked channels and book the pulses this edge must cause.
  task automatic applyStimulus(input logic [N-1:0] mask, input logic lvl,
                               input logic [N-1:0] exp_evt);
    if (lvl) async_in = async_in | mask;
    else     async_in = async_in & ~mask;
    for (int i = 0; i < N; i++) begin
      if (exp_evt[i]) sb_q.push_back('{cyc + LAT, i});
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] exp_p;
    sb_entry_t    keep[$];
    exp_p = '0;
    keep.delete();
    foreach (sb_q[j]) begin
      if (sb_q[j].due == cyc) exp_p[sb_q[j].ch] = 1'b1;
      else keep.push_back(sb_q[j]);
    end
    sb_q = keep;
    checkOutput("pulse_out", 32'(pulse_out), 32'(exp_p));
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{4'b0001, 8'b11_11_11_00, 10, 10, 4'b0001, 4'b0000, 4'b0001, 16'h0001};
    vecs[1] = '{4'b0010, 8'b11_11_10_00,  2, 10, 4'b0000, 4'b0000, 4'b0001, 16'h0001};
    vecs[2] = '{4'b0010, 8'b11_11_10_00,  3, 10, 4'b0010, 4'b0010, 4'b0011, 16'h0021};
    vecs[3] = '{4'b0100, 8'b11_10_10_00,  6, 10, 4'b0100, 4'b0100, 4'b0111, 16'h0221};
    vecs[4] = '{4'b0001, 8'b11_10_10_01,  5, 10, 4'b0000, 4'b0001, 4'b0111, 16'h0222};
    vecs[5] = '{4'b1000, 8'b11_10_10_01,  5, 10, 4'b0000, 4'b0000, 4'b0111, 16'h0222};
    vecs[6] = '{4'b1111, 8'b00_01_10_00,  4, 10, 4'b1011, 4'b0110, 4'b1111, 16'h1343};

    // Reset with random inputs: nothing may leak through while held.
    #1 rst = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      async_in = N'($urandom);
      #1;
      checkOutput("rst_flag", 32'(flag), 32'h0);
      checkOutput("rst_cnt", 32'(evt_cnt), 32'h0);
      checkOutput("rst_pulse", 32'(pulse_out), 32'h0);
    end
    @(negedge clk);
    async_in = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_flag", 32'(flag), 32'h0);
    checkOutput("post_rst_cnt", 32'(evt_cnt), 32'h0);
    waitCycles(5);

    for (int v = 0; v < NVEC; v++) begin
      mode = vecs[v].mode;
      applyStimulus(vecs[v].in_mask, 1'b1, vecs[v].exp_rise);
      waitCycles(vecs[v].hi);
      applyStimulus(vecs[v].in_mask, 1'b0, vecs[v].exp_fall);
      waitCycles(vecs[v].lo);
      checkOutput($sformatf("vec%0d_flag", v), 32'(flag), 32'(vecs[v].exp_flag));
      checkOutput($sformatf("vec%0d_cnt", v), 32'(evt_cnt), 32'(vecs[v].exp_cnt));
    end

    // ch2 disabled while toggling, then re-enabled: only the next real edge counts.
    mode = 8'b00_11_10_00;
    applyStimulus(4'b0100, 1'b1, 4'b0000); waitCycles(5);
    applyStimulus(4'b0100, 1'b0, 4'b0000); waitCycles(5);
    applyStimulus(4'b0100, 1'b1, 4'b0000); waitCycles(10);
    mode = 8'b00_10_10_00;
    waitCycles(6);
    checkOutput("disable_cnt", 32'(evt_cnt), 32'h1343);
    applyStimulus(4'b0100, 1'b0, 4'b0100); waitCycles(10);
    checkOutput("reenable_cnt", 32'(evt_cnt), 32'h1443);

    // ch3 saturation, lone clear, then clear coinciding with an event.
    for (int e = 0; e < 20; e++) begin
      applyStimulus(4'b1000, 1'b1, 4'b1000); waitCycles(4);
      applyStimulus(4'b1000, 1'b0, 4'b0000); waitCycles(4);
    end
    waitCycles(6);
    checkOutput("sat_cnt", 32'(evt_cnt), 32'hF443);
    checkOutput("sat_flag", 32'(flag), 32'hF);
    clr = 4'b1000; waitCycles(1);
    clr = 4'b0000; waitCycles(1);
    checkOutput("clr_cnt", 32'(evt_cnt), 32'h0443);
    checkOutput("clr_flag", 32'(flag), 32'h7);
    applyStimulus(4'b1000, 1'b1, 4'b1000); waitCycles(LAT - 1);
    clr = 4'b1000; waitCycles(1);
    clr = 4'b0000;
    applyStimulus(4'b1000, 1'b0, 4'b0000); waitCycles(10);
    checkOutput("clr_evt_cnt", 32'(evt_cnt), 32'h1443);
    checkOutput("clr_evt_flag", 32'(flag), 32'hF);

    // Reset mid-filter on ch0 (no pulse afterwards); ch1 held high through release.
    mode = 8'b11_11_10_00;
    applyStimulus(4'b0001, 1'b1, 4'b0000); waitCycles(3);
    rst = 1'b1;
    async_in = 4'b0010;
    #1;
    checkOutput("midrst_flag", 32'(flag), 32'h0);
    checkOutput("midrst_cnt", 32'(evt_cnt), 32'h0);
    checkOutput("midrst_pulse", 32'(pulse_out), 32'h0);
    waitCycles(2);
    rst = 1'b0;
    applyStimulus(4'b0010, 1'b1, 4'b0010);
    waitCycles(12);
    checkOutput("release_flag", 32'(flag), 32'h2);
    checkOutput("release_cnt", 32'(evt_cnt), 32'h0010);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
